// File: rtl/lut_func_eval.sv
// lut_func_eval: reloadable N_IN-input / N_OUT-output truth-table evaluator.
// After reset the table is zeroed one entry per cycle, which takes 2^N_IN
// cycles with busy high. The block then evaluates input vectors through a
// one-stage valid/ready pipeline at up to one vector per cycle.
// Optional build macro: LUT_PARITY_EN. When it is defined, each entry keeps
// an even-parity bit and an out_perr output is added.
module lut_func_eval #(
    parameter int N_IN  = 5,
    parameter int N_OUT = 12,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [N_IN-1:0]  cfg_addr,
    input  logic [N_OUT-1:0] cfg_data,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_OUT-1:0] out_f,
`ifdef LUT_PARITY_EN
    output logic             out_perr,
`endif
    output logic [CNT_W-1:0] eval_cnt
);

    localparam int DEPTH = 1 << N_IN;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Even parity bit: set so that data plus parity holds an even number of ones.
    function automatic logic even_parity(input logic [N_OUT-1:0] data);
        even_parity = ^data;
    endfunction

    state_t            state_r;
    logic [N_IN-1:0]   clr_idx_r;
    logic [N_OUT-1:0]  table_r [DEPTH];

    logic              accept_s;
    logic              drain_s;
    logic              wr_en_s;
    logic [N_IN-1:0]   wr_addr_s;
    logic [N_OUT-1:0]  wr_data_s;

`ifdef LUT_PARITY_EN
    logic              par_r [DEPTH];
    logic              wr_par_s;
`endif

    // Handshake decode. An input is taken when the output stage is empty or is
    // draining on the same edge, so a continuous stream has no bubble.
    always_comb begin
        in_ready = 1'b0;
        accept_s = 1'b0;
        drain_s  = 1'b0;
        if (state_r == ST_RUN) begin
            in_ready = (!out_valid) || out_ready;
        end else begin
            in_ready = 1'b0;
        end
        accept_s = in_valid && in_ready;
        drain_s  = out_valid && out_ready;
    end

    // Select the table write port. CLEAR owns the port, and configuration
    // writes that arrive during CLEAR are dropped rather than queued.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = {N_IN{1'b0}};
        wr_data_s = {N_OUT{1'b0}};
`ifdef LUT_PARITY_EN
        wr_par_s  = 1'b0;
`endif
        if (state_r == ST_CLEAR) begin
            wr_en_s   = 1'b1;
            wr_addr_s = clr_idx_r;
            wr_data_s = {N_OUT{1'b0}};
`ifdef LUT_PARITY_EN
            wr_par_s  = 1'b0;
`endif
        end else if (cfg_we) begin
            wr_en_s   = 1'b1;
            wr_addr_s = cfg_addr;
            wr_data_s = cfg_data;
`ifdef LUT_PARITY_EN
            wr_par_s  = even_parity(cfg_data);
`endif
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    // Table storage. It has no reset because CLEAR zeroes it after every reset.
    // Reads elsewhere see the pre-edge contents, which gives read-before-write.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            table_r[wr_addr_s] <= wr_data_s;
`ifdef LUT_PARITY_EN
            par_r[wr_addr_s]   <= wr_par_s;
`endif
        end
    end

    // Control FSM with the registered result stage, busy flag and counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_CLEAR;
            clr_idx_r <= {N_IN{1'b0}};
            busy      <= 1'b1;
            out_valid <= 1'b0;
            out_f     <= {N_OUT{1'b0}};
`ifdef LUT_PARITY_EN
            out_perr  <= 1'b0;
`endif
            eval_cnt  <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    clr_idx_r <= clr_idx_r + N_IN'(1);
                    if (clr_idx_r == {N_IN{1'b1}}) begin
                        state_r <= ST_RUN;
                        busy    <= 1'b0;
                    end else begin
                        state_r <= ST_CLEAR;
                        busy    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    state_r <= ST_RUN;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r   <= ST_CLEAR;
                    clr_idx_r <= {N_IN{1'b0}};
                    busy      <= 1'b1;
                end
            endcase

            if (accept_s) begin
                out_valid <= 1'b1;
                out_f     <= table_r[in_x];
`ifdef LUT_PARITY_EN
                out_perr  <= par_r[in_x] ^ even_parity(table_r[in_x]);
`endif
            end else if (drain_s) begin
                out_valid <= 1'b0;
            end else begin
                out_valid <= out_valid;
            end

            if (drain_s) begin
                eval_cnt <= eval_cnt + CNT_W'(1);
            end else begin
                eval_cnt <= eval_cnt;
            end
        end
    end

endmodule
